// File: rtl/lsm_pkg.sv
// rtl/lsm_pkg.sv - shared state encoding and IR field positions for the LDM/STM sequencer
package lsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } lsm_state_e;

    localparam int IR_L_BIT     = 20;
    localparam int IR_W_BIT     = 21;
    localparam int IR_U_BIT     = 23;
    localparam int IR_P_BIT     = 24;
    localparam int IR_LIST_LSB  = 0;
    localparam int IR_LIST_MSB  = 15;
    localparam int LIST_W       = IR_LIST_MSB - IR_LIST_LSB + 1;

endpackage

// File: rtl/lsm_prio_enc.sv
// rtl/lsm_prio_enc.sv - lowest-set-bit finder for the remaining register list
module lsm_prio_enc (
    input  logic [15:0] mask,
    output logic [3:0]  idx,
    output logic        valid
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        idx   = 4'd0;
        valid = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsm_sequencer.sv
// rtl/lsm_sequencer.sv - load/store-multiple beat sequencer with base write-back
module lsm_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] IR,
    input  logic [31:0] base,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] addr,
    output logic [3:0]  REG_COUNTER,
    output logic        LSM_RD_MUX,
    output logic        LATCH_REG,
    output logic        WRITE_BACK,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        done
);
    import lsm_pkg::*;

    lsm_state_e         state_q, state_d;
    logic [LIST_W-1:0]  mask_q, mask_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        base_q, base_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               l_q, l_d, w_q, w_d, u_q, u_d, p_q, p_d;

    logic [4:0]         pop_cnt;
    logic [31:0]        pop_span;
    logic [31:0]        cnt_span;
    logic [31:0]        start_addr;
    logic [3:0]         enc_idx;
    logic               enc_valid;
    logic               ir_unused;

    // Opcode bits outside L/W/U/P and the list have no meaning here
    assign ir_unused = ^{IR[31:25], IR[22], IR[19:16]};

    lsm_prio_enc u_prio_enc (
        .mask  (mask_q),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // Number of registers in the incoming list; five bits so a full list of 16 fits
    always_comb begin
        pop_cnt = 5'd0;
        for (int i = IR_LIST_LSB; i <= IR_LIST_MSB; i++) begin
            pop_cnt = pop_cnt + 5'(IR[i]);
        end
    end

    assign pop_span = {25'd0, pop_cnt, 2'b00};
    assign cnt_span = {25'd0, cnt_q, 2'b00};

    // Lowest address of the block; beats always walk upwards from here
    always_comb begin
        case ({IR[IR_P_BIT], IR[IR_U_BIT]})
            2'b01:   start_addr = base;
            2'b11:   start_addr = base + 32'd4;
            2'b00:   start_addr = base - pop_span + 32'd4;
            default: start_addr = base - pop_span;
        endcase
    end

    // Sequencer state and captured instruction fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            addr_q  <= 32'd0;
            base_q  <= 32'd0;
            cnt_q   <= 5'd0;
            l_q     <= 1'b0;
            w_q     <= 1'b0;
            u_q     <= 1'b0;
            p_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            w_q     <= w_d;
            u_q     <= u_d;
            p_q     <= p_d;
        end
    end

    // Next-state and output decode; strobes are only ever raised in their own state
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        l_d         = l_q;
        w_d         = w_q;
        u_d         = u_q;
        p_d         = p_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr        = 32'd0;
        REG_COUNTER = 4'd0;
        LSM_RD_MUX  = 1'b0;
        LATCH_REG   = 1'b0;
        WRITE_BACK  = 1'b0;
        wb_data     = 32'd0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d  = IR[IR_LIST_MSB:IR_LIST_LSB];
                    base_d  = base;
                    cnt_d   = pop_cnt;
                    addr_d  = start_addr;
                    l_d     = IR[IR_L_BIT];
                    w_d     = IR[IR_W_BIT];
                    u_d     = IR[IR_U_BIT];
                    p_d     = IR[IR_P_BIT];
                    state_d = (IR[IR_LIST_MSB:IR_LIST_LSB] == '0) ? ST_DONE : ST_XFER;
                end
            end

            ST_XFER: begin
                busy        = 1'b1;
                mem_req     = enc_valid;
                mem_we      = ~l_q;
                addr        = addr_q;
                REG_COUNTER = enc_idx;
                if (mem_ready) begin
                    mask_d     = mask_q & ~(16'd1 << enc_idx);
                    addr_d     = addr_q + 32'd4;
                    LATCH_REG  = l_q;
                    LSM_RD_MUX = l_q;
                    if (mask_d == '0) begin
                        state_d = w_q ? ST_WB : ST_DONE;
                    end
                end
            end

            ST_WB: begin
                busy       = 1'b1;
                WRITE_BACK = 1'b1;
                wb_data    = u_q ? (base_q + cnt_span) : (base_q - cnt_span);
                state_d    = ST_DONE;
            end

            default: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsm_sequencer.sv
// tb/tb_lsm_sequencer.sv - self-checking bench for lsm_sequencer
module tb_lsm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] IR;
    logic [31:0] base;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] addr;
    logic [3:0]  REG_COUNTER;
    logic        LSM_RD_MUX;
    logic        LATCH_REG;
    logic        WRITE_BACK;
    logic [31:0] wb_data;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    lsm_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .IR          (IR),
        .base        (base),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr        (addr),
        .REG_COUNTER (REG_COUNTER),
        .LSM_RD_MUX  (LSM_RD_MUX),
        .LATCH_REG   (LATCH_REG),
        .WRITE_BACK  (WRITE_BACK),
        .wb_data     (wb_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] base;
        int          stall;
        int          nb;
        logic [31:0] first_a;
        logic [31:0] last_a;
        int          nlatch;
        int          nwb;
        logic [31:0] wbd;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs one instruction; stall<0 gives random mem_ready, otherwise each beat waits 'stall' cycles.
    // Every cycle is compared against a beat list derived from the register list and addressing mode.
    task automatic run_op(input logic [31:0] ir_v, input logic [31:0] base_v, input int stall,
                          output int nb, output logic [31:0] first_a, output logic [31:0] last_a,
                          output int nlatch, output int nwb, output logic [31:0] wbd, output int lat);
        logic [31:0] exp_addr[$];
        int          exp_reg[$];
        int          n;
        int          s;
        int          cyc;
        logic        l, w, u, p, r;
        logic [31:0] lo;
        logic [31:0] exp_wb;
        l = ir_v[20];
        w = ir_v[21];
        u = ir_v[23];
        p = ir_v[24];
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (ir_v[i]) begin
                exp_reg.push_back(i);
                n++;
            end
        end
        if (u) lo = base_v + (p ? 32'd4 : 32'd0);
        else   lo = base_v - 32'(4 * n) + (p ? 32'd0 : 32'd4);
        for (int k = 0; k < n; k++) exp_addr.push_back(lo + 32'(4 * k));
        exp_wb = u ? base_v + 32'(4 * n) : base_v - 32'(4 * n);
        nb = 0; first_a = 0; last_a = 0; nlatch = 0; nwb = 0; wbd = 0; lat = -1;

        @(posedge clk); #1;
        start = 1'b1; IR = ir_v; base = base_v; mem_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; IR = $urandom; base = $urandom;
        cyc = 1;
        for (int k = 0; k < n; k++) begin
            s = 0;
            while (1) begin
                if (stall < 0) r = ($urandom_range(0, 2) != 0);
                else           r = (s >= stall);
                mem_ready = r;
                #4;
                chk("mem_req", mem_req, 1);
                chk("addr", addr, exp_addr[k]);
                chk("reg_counter", REG_COUNTER, exp_reg[k]);
                chk("mem_we", mem_we, !l);
                chk("latch_reg", LATCH_REG, r && l);
                chk("lsm_rd_mux", LSM_RD_MUX, r && l);
                chk("busy_xfer", busy, 1);
                chk("write_back_xfer", WRITE_BACK, 0);
                if (k == 0 && s == 0) first_a = addr;
                last_a = addr;
                if (LATCH_REG) nlatch++;
                if (mem_req && r) nb++;
                @(posedge clk); #1;
                cyc++;
                if (r) break;
                s++;
            end
        end
        mem_ready = 1'b0;
        if (w && n > 0) begin
            #4;
            chk("write_back", WRITE_BACK, 1);
            chk("wb_data", wb_data, exp_wb);
            chk("mem_req_wb", mem_req, 0);
            chk("busy_wb", busy, 1);
            if (WRITE_BACK) begin
                nwb++;
                wbd = wb_data;
            end
            @(posedge clk); #1;
            cyc++;
        end
        #4;
        chk("done", done, 1);
        chk("busy_done", busy, 0);
        chk("mem_req_done", mem_req, 0);
        chk("write_back_done", WRITE_BACK, 0);
        chk("latch_done", LATCH_REG, 0);
        if (done) lat = cyc;
        start = 1'b1; IR = 32'h00A0_0003; base = 32'h0000_8000;
        @(posedge clk); #1;
        start = 1'b0;
        #4;
        chk("start_in_done_ignored", mem_req, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[7];
        int          nb, nlatch, nwb, lat;
        logic [31:0] first_a, last_a, wbd;
        logic [31:0] rir;
        int          sel;

        vecs[0] = '{32'h00A0_0007, 32'h0000_1000, 0,  3, 32'h0000_1000, 32'h0000_1008, 0, 1, 32'h0000_100C, 5};
        vecs[1] = '{32'h0110_8010, 32'h0000_2000, 0,  2, 32'h0000_1FF8, 32'h0000_1FFC, 2, 0, 32'h0, 3};
        vecs[2] = '{32'h0190_0001, 32'h0000_1000, 3,  1, 32'h0000_1004, 32'h0000_1004, 1, 0, 32'h0, 5};
        vecs[3] = '{32'h00A0_0000, 32'h0000_1234, 0,  0, 32'h0, 32'h0, 0, 0, 32'h0, 1};
        vecs[4] = '{32'h0020_FFFF, 32'h0000_0100, 0, 16, 32'h0000_00C4, 32'h0000_0100, 0, 1, 32'h0000_00C0, 18};
        vecs[5] = '{32'h0100_0003, 32'h0000_0004, 1,  2, 32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 32'h0, 5};
        vecs[6] = '{32'h00B0_8001, 32'hFFFF_FFF8, 0,  2, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 2, 1, 32'h0000_0000, 4};

        rst = 1'b0; start = 1'b0; IR = 32'h0; base = 32'h0; mem_ready = 1'b0;
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_reg_counter", REG_COUNTER, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_write_back", WRITE_BACK, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            do_reset();
            run_op(vecs[i].ir, vecs[i].base, vecs[i].stall, nb, first_a, last_a, nlatch, nwb, wbd, lat);
            chk($sformatf("v%0d_beats", i), nb, vecs[i].nb);
            if (vecs[i].nb > 0) begin
                chk($sformatf("v%0d_first_addr", i), first_a, vecs[i].first_a);
                chk($sformatf("v%0d_last_addr", i), last_a, vecs[i].last_a);
            end
            chk($sformatf("v%0d_latches", i), nlatch, vecs[i].nlatch);
            chk($sformatf("v%0d_write_backs", i), nwb, vecs[i].nwb);
            chk($sformatf("v%0d_wb_data", i), wbd, vecs[i].wbd);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
        end

        // Reset during beat 2 of 4: outputs drop at once and no done follows
        do_reset();
        @(posedge clk); #1;
        start = 1'b1; IR = 32'h00A0_000F; base = 32'h0000_3000; mem_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #4;
        chk("abort_beat1_addr", addr, 32'h0000_3000);
        @(posedge clk); #1;
        #2;
        chk("abort_beat2_addr", addr, 32'h0000_3004);
        rst = 1'b0;
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_addr", addr, 0);
        chk("abort_reg_counter", REG_COUNTER, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mem_we", mem_we, 0);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #5;
            chk("abort_no_done", done, 0);
            chk("abort_no_wb", WRITE_BACK, 0);
            chk("abort_idle_req", mem_req, 0);
        end

        // Start held through reset release is taken on the first clock
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; IR = 32'h0190_0001; base = 32'h0000_5000;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mem_ready = 1'b1;
        #4;
        chk("post_reset_mem_req", mem_req, 1);
        chk("post_reset_addr", addr, 32'h0000_5004);
        chk("post_reset_latch", LATCH_REG, 1);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #4;
        chk("post_reset_done", done, 1);

        // Random instructions and random memory back-pressure against the model
        for (int t = 0; t < 30; t++) begin
            rir = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      rir[15:0] = 16'h0000;
            else if (sel == 1) rir[15:0] = 16'hFFFF;
            else if (sel == 2) rir[15:0] = 16'h0001 << $urandom_range(0, 15);
            run_op(rir, $urandom, (t % 4 == 0) ? 0 : -1, nb, first_a, last_a, nlatch, nwb, wbd, lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
